// File: rtl/stream_demux_1_4_pkg.sv
// ---------------------------------------------------------------------------
// stream_demux_pkg
// Shared types and constants for the 1-to-4 stream demultiplexer.
//   NCH          : number of output channels.
//   chan_sel_t   : channel select carried alongside each input word.
//   slot_state_t : per-channel holding slot state (EMPTY / FULL).
//   sel_decode   : one-hot decode of a channel select.
// ---------------------------------------------------------------------------
package stream_demux_pkg;

    localparam int NCH = 4;

    typedef logic [1:0] chan_sel_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic [NCH-1:0] sel_decode(input chan_sel_t sel);
        logic [NCH-1:0] onehot;
        onehot      = '0;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/stream_demux_1_4_if.sv
// ---------------------------------------------------------------------------
// stream_demux_1_4_if
// Bundles the input channel and the four output channels of the demux.
//   in_valid / in_ready / in_data / in_sel : producer-side handshake.
//   out_valid[k] / out_ready[k]           : consumer k handshake.
//   out_data0 .. out_data3                : contents of slots 0..3.
// Modports:
//   slave  : the demux itself (accepts input, drives outputs).
//   master : the environment (producer + consumers).
// ---------------------------------------------------------------------------
interface stream_demux_1_4_if
    import stream_demux_pkg::*;
#(
    parameter int W = 4
);

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    chan_sel_t      in_sel;
    logic [NCH-1:0] out_valid;
    logic [NCH-1:0] out_ready;
    logic [W-1:0]   out_data0;
    logic [W-1:0]   out_data1;
    logic [W-1:0]   out_data2;
    logic [W-1:0]   out_data3;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data0,
        output out_data1,
        output out_data2,
        output out_data3
    );

    modport master (
        output in_valid,
        output in_data,
        output in_sel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data0,
        input  out_data1,
        input  out_data2,
        input  out_data3
    );

endinterface

// File: rtl/stream_demux_1_4_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
// One-entry holding slot for a single output channel.
//   clk, rst_n   : clock, asynchronous active-low reset.
//   load         : word is being transferred into this slot this cycle.
//   load_data    : word to capture on load.
//   drain_ready  : consumer accepts the held word this cycle.
//   valid        : slot holds a word (registered).
//   data         : held word; keeps the last loaded value when empty.
//   state        : slot FSM state, used by the parent for ready muxing.
// The parent only asserts load on a FULL slot when drain_ready is also high,
// so a load while FULL is always a same-cycle reload with no bubble.
// ---------------------------------------------------------------------------
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [W-1:0] load_data,
    input  logic        drain_ready,
    output logic        valid,
    output logic [W-1:0] data,
    output slot_state_t state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
            valid <= 1'b0;
            data  <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (load) begin
                        state <= SLOT_FULL;
                        valid <= 1'b1;
                        data  <= load_data;
                    end
                end
                SLOT_FULL: begin
                    if (load) begin
                        // reload: old word leaves, new word arrives, stay FULL
                        data <= load_data;
                    end else if (drain_ready) begin
                        state <= SLOT_EMPTY;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= SLOT_EMPTY;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/stream_demux_1_4.sv
// ---------------------------------------------------------------------------
// stream_demux_1_4
// Registered 1-to-4 stream demultiplexer. Each input word is routed to the
// output channel named by in_sel and held in that channel's one-entry slot
// until its consumer takes it. A stalled consumer blocks only words
// addressed to its own channel.
//   clk, rst_n : clock, asynchronous active-low reset.
//   bus        : stream_demux_1_4_if.slave
//                in_valid/in_ready/in_data/in_sel  - producer handshake
//                out_valid/out_ready/out_data0..3  - consumer handshakes
// ---------------------------------------------------------------------------
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_demux_1_4_if.slave   bus
);

    slot_state_t    slot_state [NCH];
    logic [W-1:0]   slot_data  [NCH];
    logic [NCH-1:0] slot_valid;
    logic [NCH-1:0] slot_load;
    logic           in_ready;
    logic           in_xfer;

    // Ready reflects only the addressed slot; in_valid is deliberately
    // not part of this term.
    always_comb begin
        in_ready = (slot_state[bus.in_sel] != SLOT_FULL) || bus.out_ready[bus.in_sel];
    end

    always_comb begin
        in_xfer   = bus.in_valid && in_ready;
        slot_load = sel_decode(bus.in_sel) & {NCH{in_xfer}};
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot #(
            .W (W)
        ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .load        (slot_load[k]),
            .load_data   (bus.in_data),
            .drain_ready (bus.out_ready[k]),
            .valid       (slot_valid[k]),
            .data        (slot_data[k]),
            .state       (slot_state[k])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = slot_valid;
    assign bus.out_data0 = slot_data[0];
    assign bus.out_data1 = slot_data[1];
    assign bus.out_data2 = slot_data[2];
    assign bus.out_data3 = slot_data[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
// ---------------------------------------------------------------------------
// tb_stream_demux_1_4
// Self-checking bench for stream_demux_1_4 (W = 4). Directed vectors come
// from a table; randomized traffic is checked against a queue-based model
// of four independent one-deep channels.
// ---------------------------------------------------------------------------
module tb_stream_demux_1_4;
    import stream_demux_pkg::*;

    localparam int W = 4;

    logic clk;
    logic rst_n;

    stream_demux_1_4_if #(.W(W)) bus ();

    stream_demux_1_4 #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each channel is a queue holding at most one word,
    // plus the last word ever delivered to that channel.
    logic [W-1:0] mq    [NCH][$];
    logic [W-1:0] mlast [NCH];

    typedef struct {
        logic        v;
        logic [1:0]  s;
        logic [3:0]  d;
        logic [3:0]  r;
        logic        e_rdy;
        logic [3:0]  e_val;
        logic [15:0] e_data;   // {d3,d2,d1,d0}
    } vec_t;

    vec_t tbl [11];

    logic [W-1:0] rx [NCH][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] dut_data();
        return {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0};
    endfunction

    function automatic logic model_rdy();
        return (mq[bus.in_sel].size() == 0) || bus.out_ready[bus.in_sel];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            mq[k].delete();
            mlast[k] = '0;
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] r);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    // Advance one clock and update the model from the inputs applied.
    task automatic tick();
        logic rdy;
        rdy = model_rdy();
        @(posedge clk);
        for (int k = 0; k < NCH; k++)
            if (mq[k].size() != 0 && bus.out_ready[k]) void'(mq[k].pop_front());
        if (bus.in_valid && rdy) begin
            mq[bus.in_sel].push_back(bus.in_data);
            mlast[bus.in_sel] = bus.in_data;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [3:0]  ev;
        logic [15:0] dd;
        dd = dut_data();
        for (int k = 0; k < NCH; k++) ev[k] = (mq[k].size() != 0);
        check($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'(model_rdy()));
        check($sformatf("%s out_valid", tag), 32'(bus.out_valid), 32'(ev));
        for (int k = 0; k < NCH; k++)
            check($sformatf("%s out_data%0d", tag, k), 32'(dd[k*4 +: 4]), 32'(mlast[k]));
    endtask

    task automatic collect();
        logic [15:0] dd;
        dd = dut_data();
        for (int k = 0; k < NCH; k++)
            if (bus.out_valid[k] && bus.out_ready[k]) rx[k].push_back(dd[k*4 +: 4]);
    endtask

    initial begin
        int acc;

        // single routing, stall isolation, reload without bubble
        tbl[0]  = '{1'b1, 2'd2, 4'hA, 4'hF, 1'b1, 4'b0000, 16'h0000};
        tbl[1]  = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0100, 16'h0A00};
        tbl[2]  = '{1'b1, 2'd0, 4'h3, 4'hE, 1'b1, 4'b0000, 16'h0A00};
        tbl[3]  = '{1'b1, 2'd0, 4'h5, 4'hE, 1'b0, 4'b0001, 16'h0A03};
        tbl[4]  = '{1'b1, 2'd1, 4'h7, 4'hE, 1'b1, 4'b0001, 16'h0A03};
        tbl[5]  = '{1'b0, 2'd0, 4'h0, 4'hE, 1'b0, 4'b0011, 16'h0A73};
        tbl[6]  = '{1'b0, 2'd1, 4'h0, 4'hE, 1'b1, 4'b0001, 16'h0A73};
        tbl[7]  = '{1'b1, 2'd3, 4'h1, 4'hE, 1'b1, 4'b0001, 16'h0A73};
        tbl[8]  = '{1'b1, 2'd3, 4'h2, 4'hE, 1'b1, 4'b1001, 16'h1A73};
        tbl[9]  = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b1001, 16'h2A73};
        tbl[10] = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0000, 16'h2A73};

        // Reset held with a valid word presented: nothing may load.
        rst_n = 1'b0;
        drive(1'b1, 2'd1, 4'hF, 4'h0);
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("reset in_ready", 32'(bus.in_ready), 32'd1);
            check("reset out_valid", 32'(bus.out_valid), 32'd0);
            check("reset out_data", 32'(dut_data()), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        @(negedge clk);
        check_model("post-reset");
        tick();

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r);
            @(negedge clk);
            check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_val));
            check($sformatf("vec%0d out_data", i), 32'(dut_data()), 32'(tbl[i].e_data));
            tick();
        end

        // Back-to-back stream of 16 words, sel = word[1:0].
        acc = 0;
        for (int k = 0; k < NCH; k++) rx[k].delete();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] w;
            w = 4'(i);
            drive(1'b1, w[1:0], w, 4'hF);
            @(negedge clk);
            check_model($sformatf("b2b%0d", i));
            if (bus.in_ready) acc++;
            collect();
            tick();
        end
        repeat (2) begin
            drive(1'b0, 2'd0, 4'h0, 4'hF);
            @(negedge clk);
            collect();
            tick();
        end
        check("b2b transfers", 32'(acc), 32'd16);
        for (int k = 0; k < NCH; k++) begin
            check($sformatf("b2b rx%0d count", k), 32'(rx[k].size()), 32'd4);
            for (int j = 0; j < 4; j++)
                if (j < rx[k].size())
                    check($sformatf("b2b rx%0d[%0d]", k, j), 32'(rx[k][j]), 32'(k + 4 * j));
        end

        // Fill all slots with consumers stalled, then reset between edges.
        for (int k = 0; k < NCH; k++) begin
            drive(1'b1, 2'(k), 4'(4'h8 + k), 4'h0);
            tick();
        end
        drive(1'b0, 2'd0, 4'h0, 4'h0);
        @(negedge clk);
        check_model("full");
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst out_data", 32'(dut_data()), 32'd0);
        check("midrst in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        @(negedge clk);
        check_model("after midrst");
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 1) == 1) r = 4'($urandom);
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), r);
            @(negedge clk);
            check_model($sformatf("rnd%0d", i));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
